// File: rtl/uart_lcd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_lcd_pkg
// Description : Shared types and constants for the UART-to-LCD line assembler.
//               Holds the FSM state type, the byte classification type, the
//               control-character codes and the byte classifier.
// Revision    : 1.0  initial release
// ============================================================================
package uart_lcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CL_IGNORE = 3'd0,
        CL_PRINT  = 3'd1,
        CL_CR     = 3'd2,
        CL_LF     = 3'd3,
        CL_BS     = 3'd4,
        CL_FF     = 3'd5
    } byte_class_t;

    localparam logic [7:0] CH_CR             = 8'h0D;
    localparam logic [7:0] CH_LF             = 8'h0A;
    localparam logic [7:0] CH_BS             = 8'h08;
    localparam logic [7:0] CH_FF             = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO       = 8'h20;
    localparam logic [7:0] CH_PRINT_HI       = 8'h7E;
    localparam logic [7:0] DEFAULT_FILL_CHAR = 8'h20;

    function automatic byte_class_t classify(input logic [7:0] b);
        byte_class_t cls;
        cls = CL_IGNORE;
        if (b >= CH_PRINT_LO && b <= CH_PRINT_HI) begin
            cls = CL_PRINT;
        end else begin
            case (b)
                CH_CR:   cls = CL_CR;
                CH_LF:   cls = CL_LF;
                CH_BS:   cls = CL_BS;
                CH_FF:   cls = CL_FF;
                default: cls = CL_IGNORE;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_line_assembler_neg_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : neg_edge_detect
// Description : Registers a level and flags its falling edge combinationally.
//               fall_o is high in the cycle where the previous sample was 1
//               and the current input is 0.
// Ports       : clk    - clock
//               rst_n  - synchronous active-low reset (history cleared to 0)
//               sig_i  - level to watch
//               fall_o - falling-edge pulse
// Revision    : 1.0  initial release
// ============================================================================
module neg_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign fall_o = sig_q & ~sig_i;

endmodule
`default_nettype wire

// File: rtl/uart_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_assembler
// Description : Turns the UART receive byte stream into two LCD line images.
//               Tracks the cursor, handles CR/LF/BS/FF, wraps from line 1 to
//               line 2 and scrolls line 2 up when writing past the end.
//               Optional echo of accepted bytes is enabled by defining the
//               ECHO_EN macro (ECHO_HOLD exists only in that build).
// Ports       : clk          - system clock
//               rst_n        - synchronous active-low reset
//               rx_data      - received byte, valid on rx_int falling edge
//               rx_int       - receiver busy; falling edge = byte complete
//               clear        - synchronous clear of lines/cursor/overrun
//               line1_buffer - top line, char 0 in the MSB byte
//               line2_buffer - bottom line, same layout
//               cursor_pos   - 0..LINE_CHARS-1 line 1, above that line 2
//               overrun      - sticky: byte completed while still busy
//               echo_data    - last echoed byte (0 without ECHO_EN)
//               echo_int     - echo strobe, falling edge starts tx
// Revision    : 1.0  initial release
// ============================================================================
module uart_line_assembler
    import uart_lcd_pkg::*;
#(
`ifdef ECHO_EN
    parameter int         ECHO_HOLD  = 2,
`endif
    parameter int         LINE_CHARS = 16,
    parameter logic [7:0] FILL_CHAR  = DEFAULT_FILL_CHAR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_int,
    input  logic                              clear,
    output logic [LINE_CHARS*8-1:0]           line1_buffer,
    output logic [LINE_CHARS*8-1:0]           line2_buffer,
    output logic [$clog2(2*LINE_CHARS)-1:0]   cursor_pos,
    output logic                              overrun,
    output logic [7:0]                        echo_data,
    output logic                              echo_int
);

    localparam int              BW        = LINE_CHARS * 8;
    localparam int              NCH       = 2 * LINE_CHARS;
    localparam int              CW        = $clog2(NCH);
    localparam logic [BW-1:0]   FILL_LINE = {LINE_CHARS{FILL_CHAR}};
    localparam logic [CW-1:0]   C_LINE2   = CW'(LINE_CHARS);
    localparam logic [CW-1:0]   C_LAST    = CW'(NCH - 1);

    state_t         state_q, state_d;
    byte_class_t    class_q, class_d;
    logic [7:0]     byte_q, byte_d;
    logic [BW-1:0]  line1_q, line1_d;
    logic [BW-1:0]  line2_q, line2_d;
    logic [CW-1:0]  cursor_q, cursor_d;
    logic           overrun_q, overrun_d;
    logic [2*BW-1:0] screen;
    logic           fall;

    neg_edge_detect u_rx_fall (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (rx_int),
        .fall_o (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            class_q   <= CL_IGNORE;
            byte_q    <= 8'h00;
            line1_q   <= FILL_LINE;
            line2_q   <= FILL_LINE;
            cursor_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            byte_q    <= byte_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
            cursor_q  <= cursor_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        byte_d    = byte_q;
        line1_d   = line1_q;
        line2_d   = line2_q;
        cursor_d  = cursor_q;
        overrun_d = overrun_q;
        // Both lines viewed as one 2*LINE_CHARS character strip so the cursor
        // indexes straight into it.
        screen    = {line1_q, line2_q};

        if (clear) begin
            // Aborts any in-flight byte; a fall in this cycle is discarded.
            state_d   = IDLE;
            line1_d   = FILL_LINE;
            line2_d   = FILL_LINE;
            cursor_d  = '0;
            overrun_d = 1'b0;
        end else begin
            if (fall && state_q != IDLE) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        byte_d  = rx_data;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    class_d = classify(byte_q);
                    state_d = UPDATE;
                end
                UPDATE: begin
                    state_d = IDLE;
                    case (class_q)
                        CL_PRINT: begin
                            for (int k = 0; k < NCH; k++) begin
                                if (CW'(k) == cursor_q) screen[(NCH-1-k)*8 +: 8] = byte_q;
                            end
                            if (cursor_q == C_LAST) begin
                                // Last char of line 2 was just written, so it
                                // moves up with the rest of line 2.
                                line1_d  = screen[BW-1:0];
                                line2_d  = FILL_LINE;
                                cursor_d = C_LINE2;
                            end else begin
                                line1_d  = screen[2*BW-1:BW];
                                line2_d  = screen[BW-1:0];
                                cursor_d = cursor_q + CW'(1);
                            end
                        end
                        CL_CR: begin
                            cursor_d = (cursor_q < C_LINE2) ? '0 : C_LINE2;
                        end
                        CL_LF: begin
                            if (cursor_q < C_LINE2) begin
                                cursor_d = cursor_q + C_LINE2;
                            end else begin
                                line1_d = line2_q;
                                line2_d = FILL_LINE;
                            end
                        end
                        CL_BS: begin
                            if (cursor_q != '0) begin
                                cursor_d = cursor_q - CW'(1);
                                for (int k = 0; k < NCH; k++) begin
                                    if (CW'(k) == cursor_q - CW'(1)) screen[(NCH-1-k)*8 +: 8] = FILL_CHAR;
                                end
                                line1_d = screen[2*BW-1:BW];
                                line2_d = screen[BW-1:0];
                            end
                        end
                        CL_FF: begin
                            line1_d  = FILL_LINE;
                            line2_d  = FILL_LINE;
                            cursor_d = '0;
                        end
                        default: begin
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign line1_buffer = line1_q;
    assign line2_buffer = line2_q;
    assign cursor_pos   = cursor_q;
    assign overrun      = overrun_q;

`ifdef ECHO_EN
    localparam int HW = $clog2(ECHO_HOLD + 1);

    logic           echo_load;
    logic [HW-1:0]  hold_q;
    logic [7:0]     echo_data_q;
    logic           echo_int_q;

    // Same condition under which UPDATE commits a non-ignored byte.
    assign echo_load = (state_q == UPDATE) && !clear && (class_q != CL_IGNORE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= '0;
            echo_data_q <= 8'h00;
            echo_int_q  <= 1'b0;
        end else if (echo_load) begin
            // A new echo restarts the hold window with the new byte.
            echo_data_q <= byte_q;
            echo_int_q  <= 1'b1;
            hold_q      <= HW'(ECHO_HOLD - 1);
        end else if (echo_int_q) begin
            if (hold_q == '0) begin
                echo_int_q <= 1'b0;
            end else begin
                hold_q <= hold_q - HW'(1);
            end
        end
    end

    assign echo_data = echo_data_q;
    assign echo_int  = echo_int_q;
`else
    assign echo_data = 8'h00;
    assign echo_int  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_line_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_line_assembler
// Description : Self-checking bench for uart_line_assembler. A character-array
//               model of the display produces expected snapshots that a
//               monitor compares against the DUT every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_line_assembler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_int = 1'b0;
    logic         clear = 1'b0;
    logic [127:0] line1_buffer;
    logic [127:0] line2_buffer;
    logic [4:0]   cursor_pos;
    logic         overrun;
    logic [7:0]   echo_data;
    logic         echo_int;

    uart_line_assembler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_int       (rx_int),
        .clear        (clear),
        .line1_buffer (line1_buffer),
        .line2_buffer (line2_buffer),
        .cursor_pos   (cursor_pos),
        .overrun      (overrun),
        .echo_data    (echo_data),
        .echo_int     (echo_int)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [127:0] l1;
        logic [127:0] l2;
        logic [4:0]   cur;
        logic         ovr;
    } snap_t;

    snap_t      snap_q[$];
    logic [7:0] echo_q[$];
    snap_t      exp_s;
    bit         have_exp = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    // Reference model: 32 display cells, cursor and sticky overrun flag.
    logic [7:0] scr[32];
    int         m_cur;
    bit         m_ovr;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_line(input int base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = scr[base+i];
        return v;
    endfunction

    function automatic void model_blank();
        for (int i = 0; i < 32; i++) scr[i] = 8'h20;
        m_cur = 0;
    endfunction

    function automatic void model_scroll();
        for (int i = 0; i < 16; i++) begin
            scr[i]    = scr[i+16];
            scr[i+16] = 8'h20;
        end
    endfunction

    function automatic bit is_known(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E) || b == 8'h0D || b == 8'h0A || b == 8'h08 || b == 8'h0C;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[m_cur] = b;
            if (m_cur == 31) begin
                model_scroll();
                m_cur = 16;
            end else begin
                m_cur = m_cur + 1;
            end
        end else if (b == 8'h0D) begin
            m_cur = (m_cur < 16) ? 0 : 16;
        end else if (b == 8'h0A) begin
            if (m_cur < 16) m_cur = m_cur + 16;
            else model_scroll();
        end else if (b == 8'h08) begin
            if (m_cur > 0) begin
                m_cur = m_cur - 1;
                scr[m_cur] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            model_blank();
        end
    endfunction

    task automatic push_snap(input int due);
        snap_t s;
        s.due = due;
        s.l1  = pack_line(0);
        s.l2  = pack_line(16);
        s.cur = 5'(m_cur);
        s.ovr = m_ovr;
        snap_q.push_back(s);
    endtask

    task automatic push_echo(input logic [7:0] b);
`ifdef ECHO_EN
        if (is_known(b)) echo_q.push_back(b);
`else
        if (is_known(b)) begin
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_int  = 1'b1;
        tick(); tick();
        rx_int  = 1'b0;
        model_byte(b);
        push_snap(cyc + 3);
        push_echo(b);
        tick(); tick(); tick();
    endtask

    // Second byte completes while the first is still being processed.
    task automatic send_overrun(input logic [7:0] b1, input logic [7:0] b2);
        rx_data = b1;
        rx_int  = 1'b1;
        tick(); tick();
        rx_int  = 1'b0;
        model_byte(b1);
        m_ovr = 1'b1;
        push_snap(cyc + 3);
        push_echo(b1);
        tick();
        rx_int  = 1'b1;
        rx_data = b2;
        tick();
        rx_int  = 1'b0;
        tick(); tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_blank();
        m_ovr = 1'b0;
        push_snap(cyc + 1);
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Clear lands k cycles after the byte's falling edge (k=0: same cycle).
    task automatic clear_abort(input logic [7:0] b, input int k);
        rx_data = b;
        rx_int  = 1'b1;
        tick(); tick();
        rx_int  = 1'b0;
        for (int i = 0; i < k; i++) tick();
        do_clear();
        tick();
    endtask

    logic       prev_echo = 1'b0;
    int         hi_len = 0;
    bit         echo_seen = 1'b0;

    always @(negedge clk) begin
        if (snap_q.size() > 0 && snap_q[0].due == cyc) begin
            exp_s    = snap_q.pop_front();
            have_exp = 1'b1;
        end
        if (have_exp) begin
            chk("line1", line1_buffer, exp_s.l1);
            chk("line2", line2_buffer, exp_s.l2);
            chk("cursor", 128'(cursor_pos), 128'(exp_s.cur));
            chk("overrun", 128'(overrun), 128'(exp_s.ovr));
        end
`ifdef ECHO_EN
        if (echo_int) begin
            hi_len++;
        end else if (prev_echo) begin
            if (echo_q.size() == 0) begin
                chk("echo_unexpected", 128'(echo_data), 128'hX);
            end else begin
                chk("echo_data", 128'(echo_data), 128'(echo_q.pop_front()));
                chk("echo_hold", 128'(hi_len), 128'd2);
            end
            hi_len = 0;
        end
        prev_echo = echo_int;
`else
        if (echo_int || echo_data != 8'h00) echo_seen = 1'b1;
`endif
    end

    initial begin
        int r;
        logic [7:0] b;
        model_blank();
        m_ovr = 1'b0;
        rst_n = 1'b0;
        tick();
        push_snap(cyc);
        tick();
        rst_n = 1'b1;
        tick();

        // "HI"
        send_byte(8'h48);
        send_byte(8'h49);

        // Fill both lines, scroll on 32nd char, then one more.
        send_byte(8'h0C);
        for (int i = 0; i < 32; i++) send_byte(8'h41);
        send_byte(8'h42);

        // Backspace at cursor 5 and at cursor 0.
        send_byte(8'h0C);
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        send_byte(8'h08);
        send_byte(8'h0C);
        send_byte(8'h08);

        // CR on line 2, then LF scroll.
        send_byte(8'h0A);
        for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i));
        send_byte(8'h0D);
        send_byte(8'h0A);

        // Overrun then clear.
        send_overrun(8'h31, 8'h32);
        tick();
        do_clear();

        // Reset during UPDATE of 8'h5A, then an ignored byte.
        rx_data = 8'h5A;
        rx_int  = 1'b1;
        tick(); tick();
        rx_int  = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        model_blank();
        m_ovr = 1'b0;
        push_snap(cyc + 1);
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h07);

        // Aborted bytes: clear in fall, DECODE and UPDATE cycles.
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h55);
            clear_abort(8'h58, k);
        end

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      b = 8'($urandom_range(32, 126));
            else if (r < 63) b = 8'h0D;
            else if (r < 71) b = 8'h0A;
            else if (r < 81) b = 8'h08;
            else if (r < 83) b = 8'h0C;
            else             b = 8'h80 | 8'($urandom_range(0, 127));
            r = $urandom_range(0, 99);
            if (r < 4)       send_overrun(b, 8'($urandom_range(0, 255)));
            else if (r < 7)  do_clear();
            else if (r < 9)  clear_abort(b, $urandom_range(0, 2));
            else             send_byte(b);
        end

        repeat (6) tick();
        chk("snap_queue_drained", 128'(snap_q.size()), 128'd0);
`ifdef ECHO_EN
        chk("echo_queue_drained", 128'(echo_q.size()), 128'd0);
`else
        chk("echo_tied_low", 128'(echo_seen), 128'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_line_assembler.md
Name: uart_line_assembler

Overview:
Consumes the byte stream from the UART receiver (rx_data, rx_int) and assembles it into the two 16-character LCD line images (line1_buffer, line2_buffer) that feed lcd16x2_ctrl.
Handles cursor tracking, control characters, line wrap and scroll.
Optionally echoes each accepted byte toward my_uart_tx.
Sits between my_uart_rx and the LCD controller.

Parameters:
LINE_CHARS, 16, characters per line; buffers are LINE_CHARS*8 bits wide.
FILL_CHAR, 8'h20, character written on clear, scroll and backspace.
ECHO_HOLD, 2, cycles echo_int stays high before its falling edge.

Ports:
clk  in  1  system clock (50 MHz).
rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
rx_data  in  8  received byte; valid when rx_int falls.
rx_int  in  1  high while the receiver is busy; falling edge marks byte complete.
clear  in  1  synchronous clear request, one-cycle pulse or level.
line1_buffer  out  128  top line; char 0 at [127:120], char 15 at [7:0].
line2_buffer  out  128  bottom line, same layout.
cursor_pos  out  5  0..31; 0-15 line 1, 16-31 line 2.
overrun  out  1  sticky; set when a byte completes while busy.
echo_data  out  8  echoed byte (ECHO_EN only).
echo_int  out  1  high ECHO_HOLD cycles, then low; the falling edge starts tx (ECHO_EN only).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - line buffers all FILL_CHAR.
  - cursor_pos=0, overrun=0, echo_data=0, echo_int=0.
  - state IDLE, rx_int_d=0.
- Edge detect: register rx_int_d<=rx_int; fall = rx_int_d & ~rx_int.
- FSM states:
  - IDLE: on fall, latch rx_data into byte_q, go DECODE.
  - DECODE: classify byte_q, go UPDATE.
  - UPDATE: apply the change, go IDLE.
  - Buffers and cursor_pos change on the edge leaving UPDATE, i.e. visible 3 cycles after the cycle fall is detected.
- Byte classes (c = cursor_pos):
  - Printable 8'h20-8'h7E: write at c, then c+1.
    - If c==31: copy line2 into line1, fill line2 with FILL_CHAR, cursor=16.
    - c==15 moves to 16 with no scroll.
  - 8'h0D CR: c<=0 if c<16, else c<=16.
  - 8'h0A LF: if c<16, c<=c+16. If c>=16, scroll as above and keep c.
  - 8'h08 BS: if c>0, c<=c-1 and write FILL_CHAR at c-1. At c==0, no-op.
  - 8'h0C FF: both lines FILL_CHAR, c<=0.
  - All other bytes: ignored. No buffer or cursor change, no echo.
- Overrun:
  - fall seen in DECODE or UPDATE: byte dropped, overrun<=1.
  - overrun clears only on reset or clear.
- clear:
  - Highest priority after reset. Next edge: lines FILL_CHAR, c=0, overrun=0, FSM to IDLE.
  - Aborts any in-flight byte, which is then not written or echoed.
  - fall in the same cycle as clear is discarded.
- Simultaneous scroll and write at c==31: the written char lands in line1[7:0] after the copy, because it was line2 char 15.
- Width rule: cursor arithmetic is 5-bit; it never exceeds 31.

Optional Feature:
ECHO_EN
- Defined:
  - In UPDATE, every non-ignored byte loads echo_data<=byte_q and raises echo_int for ECHO_HOLD cycles, then drives it low.
  - A new echo while echo_int is high restarts the hold counter with the new data.
- Undefined: echo_data and echo_int are tied 0 and the hold counter is not instantiated.

Decomposition:
- Package uart_lcd_pkg:
  - state enum (IDLE, DECODE, UPDATE).
  - Constants CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_FF=8'h0C, CH_PRINT_LO=8'h20, CH_PRINT_HI=8'h7E.
  - Default FILL_CHAR.
- One natural sub-module: neg_edge_detect (register plus falling-edge pulse), reusable for rx_int. Buffer write/scroll logic stays inline.

Test Plan:
1. Reset, then send "HI" (8'h48, 8'h49) -> line1[127:112]=16'h4849, rest 8'h20, cursor_pos=2, echo_int falls twice with echo_data 8'h48 then 8'h49.
2. Send 32 x 8'h41 then 8'h42 -> after 32nd byte line1 all 8'h41, line2 all 8'h20, cursor 16. After 8'h42: line2[127:120]=8'h42, cursor 17.
3. Cursor 5: send 8'h08 -> cursor 4, char 4 = 8'h20. At cursor 0: 8'h08 -> no change.
4. Cursor 20: send 8'h0D -> cursor 16. Then 8'h0A -> scroll, line2 all 8'h20, cursor 16.
5. Second rx_int falling edge one cycle after the first -> second byte dropped, overrun=1. Pulse clear -> buffers 8'h20, cursor 0, overrun 0.
6. Assert rst_n=0 during UPDATE of 8'h5A -> next cycle all outputs at reset values, 8'h5A absent. Send 8'h07 -> no change, no echo.
